// File: rtl/mcc_pkg.sv
// mcc_pkg: state encodings, opcode/funct constants and ALU_OP codes for multi_cycle_ctrl.
package mcc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

endpackage

// File: rtl/mcc_alu_dec.sv
// mcc_alu_dec: op_code/funct to ALU_OP map plus unsupported-instruction flag.
// jal is accepted only when MCC_JAL_EN is defined.
module mcc_alu_dec
    import mcc_pkg::*;
(
    input  logic [5:0] op_code_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       unsup_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        unsup_o  = 1'b0;
        case (op_code_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_XOR:  alu_op_o = ALU_XOR;
                    FN_NOR:  alu_op_o = ALU_NOR;
                    FN_SLTU: alu_op_o = ALU_SLTU;
                    FN_SLLV: alu_op_o = ALU_SLLV;
                    default: unsup_o  = 1'b1;
                endcase
            end
            OP_ADDI:                alu_op_o = ALU_ADD;
            OP_ANDI:                alu_op_o = ALU_AND;
            OP_ORI:                 alu_op_o = ALU_OR;
            OP_XORI:                alu_op_o = ALU_XOR;
            OP_SLTIU:               alu_op_o = ALU_SLTU;
            OP_LW, OP_SW, OP_J:     alu_op_o = ALU_ADD;
            OP_BEQ, OP_BNE:         alu_op_o = ALU_SUB;
`ifdef MCC_JAL_EN
            OP_JAL:                 alu_op_o = ALU_ADD;
`endif
            default:                unsup_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-subset control FSM with retired-instruction counter.
// Define MCC_JAL_EN to support jal; otherwise jal decodes as illegal.
module multi_cycle_ctrl
    import mcc_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op_code,
    input  logic [5:0]          funct,
    input  logic                ZF,
    output logic                PC_Write,
    output logic [1:0]          PC_s,
    output logic                IR_Write,
    output logic                Reg_Write,
    output logic [1:0]          rd_s,
    output logic [1:0]          w_data_s,
    output logic                ALU_SrcA,
    output logic [1:0]          ALU_SrcB,
    output logic                Mem_Write,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [CNT_W-1:0]    inst_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       alu_op;
    logic             unsup, r_type, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, imm_s, imm_z;

    mcc_alu_dec u_dec (
        .op_code_i (op_code),
        .funct_i   (funct),
        .alu_op_o  (alu_op),
        .unsup_o   (unsup)
    );

    assign r_type = op_code == OP_RTYPE;
    assign is_lw  = op_code == OP_LW;
    assign is_sw  = op_code == OP_SW;
    assign is_beq = op_code == OP_BEQ;
    assign is_bne = op_code == OP_BNE;
    assign is_j   = op_code == OP_J;
    assign imm_s  = op_code == OP_ADDI || op_code == OP_SLTIU;
    assign imm_z  = op_code == OP_ANDI || op_code == OP_ORI || op_code == OP_XORI;
`ifdef MCC_JAL_EN
    assign is_jal = op_code == OP_JAL;
`else
    assign is_jal = 1'b0;
`endif

    assign ALU_OP   = ALU_OP_W'(alu_op);
    assign rd_s     = is_jal ? 2'b10 : r_type ? 2'b01 : 2'b00;
    assign w_data_s = is_jal ? 2'b10 : is_lw ? 2'b01 : 2'b00;
    assign state    = state_q;
    assign inst_cnt = cnt_q;

    // Enables decode from the registered state, so async reset clears them at once.
    always_comb begin
        state_d   = S_IF;
        PC_Write  = 1'b0;
        PC_s      = 2'b00;
        IR_Write  = 1'b0;
        Reg_Write = 1'b0;
        Mem_Write = 1'b0;
        ALU_SrcA  = 1'b0;
        ALU_SrcB  = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                IR_Write = 1'b1;
                PC_Write = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                illegal  = unsup;
                PC_Write = !unsup && (is_j || is_jal);
                PC_s     = (!unsup && (is_j || is_jal)) ? 2'b10 : 2'b00;
                state_d  = (unsup || is_j) ? S_IF : is_jal ? S_WB : S_EXE;
            end
            S_EXE: begin
                ALU_SrcA = 1'b1;
                ALU_SrcB = imm_z ? 2'b10 : (imm_s || is_lw || is_sw) ? 2'b01 : 2'b00;
                PC_Write = (is_beq && ZF) || (is_bne && !ZF);
                PC_s     = (is_beq || is_bne) ? 2'b01 : 2'b00;
                state_d  = (is_beq || is_bne) ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                Mem_Write = is_sw;
                state_d   = is_lw ? S_WB : S_IF;
            end
            S_WB: begin
                Reg_Write = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    assign cnt_d = (state_d == S_IF && state_q inside {S_ID, S_EXE, S_MEM, S_WB})
                   ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed scenarios plus random instruction stream checked against a table-driven model.
// Narrow counter width exercises inst_cnt wrap; define MCC_JAL_EN to check the jal path.
module tb_multi_cycle_ctrl;

    localparam int CW = 4;
`ifdef MCC_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif
    // R-type funct codes indexed by their ALU_OP code
    localparam logic [5:0] R_FN [8] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                        6'b100000, 6'b100010, 6'b101011, 6'b000100};
    localparam logic [5:0] OPS [13] = '{6'd0, 6'd0, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
                                        6'b001011, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                        6'b000010, 6'b000011};

    typedef enum {K_R, K_IS, K_IZ, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_e;

    logic          clk = 1'b0, rst = 1'b0, ZF = 1'b0;
    logic [5:0]    op_code = '0, funct = '0;
    logic          PC_Write, IR_Write, Reg_Write, Mem_Write, ALU_SrcA, illegal;
    logic [1:0]    PC_s, rd_s, w_data_s, ALU_SrcB;
    logic [2:0]    ALU_OP, state;
    logic [CW-1:0] inst_cnt;
    int            n_checks = 0, n_fail = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.ALU_OP_W(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .ZF(ZF),
        .PC_Write(PC_Write), .PC_s(PC_s), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
        .rd_s(rd_s), .w_data_s(w_data_s), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB),
        .Mem_Write(Mem_Write), .ALU_OP(ALU_OP), .state(state), .illegal(illegal),
        .inst_cnt(inst_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn, output logic [2:0] alu);
        alu = 3'd4;
        if (op == 6'd0) begin
            for (int i = 0; i < 8; i++)
                if (R_FN[i] == fn) begin
                    alu = 3'(i);
                    return K_R;
                end
            return K_ILL;
        end
        case (op)
            6'b001000: return K_IS;
            6'b001011: begin alu = 3'd6; return K_IS; end
            6'b001100: begin alu = 3'd0; return K_IZ; end
            6'b001101: begin alu = 3'd1; return K_IZ; end
            6'b001110: begin alu = 3'd2; return K_IZ; end
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: begin alu = 3'd5; return K_BEQ; end
            6'b000101: begin alu = 3'd5; return K_BNE; end
            6'b000010: return K_J;
            6'b000011: return JAL_EN ? K_JAL : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [4:0] enables();
        return {PC_Write, IR_Write, Reg_Write, Mem_Write, illegal};
    endfunction

    // Entered with the DUT in IF, sampled 1 time unit after the edge.
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic zf);
        logic [2:0] alu, path[$];
        logic [4:0] en;
        kind_e      k;
        k = classify(op, fn, alu);
        case (k)
            K_R, K_IS, K_IZ: path = {3'd2, 3'd3, 3'd5};
            K_LW:            path = {3'd2, 3'd3, 3'd4, 3'd5};
            K_SW:            path = {3'd2, 3'd3, 3'd4};
            K_BEQ, K_BNE:    path = {3'd2, 3'd3};
            K_JAL:           path = {3'd2, 3'd5};
            default:         path = {3'd2};
        endcase
        check({nm, ".if_state"}, 32'(state), 32'd1);
        check({nm, ".if_en"}, 32'(enables()), 32'b11000);
        check({nm, ".if_pcs"}, 32'(PC_s), 32'd0);
        op_code = op;
        funct   = fn;
        ZF      = zf;
        foreach (path[i]) begin
            @(posedge clk);
            #1;
            check({nm, ".state"}, 32'(state), 32'(path[i]));
            en = '0;
            case (path[i])
                3'd2: begin
                    en[4] = k == K_J || k == K_JAL;
                    en[0] = k == K_ILL;
                    if (en[4]) check({nm, ".id_pcs"}, 32'(PC_s), 32'd2);
                end
                3'd3: begin
                    check({nm, ".alu_op"}, 32'(ALU_OP), 32'(alu));
                    if (k == K_BEQ || k == K_BNE) begin
                        en[4] = (k == K_BEQ) ? zf : !zf;
                        check({nm, ".br_pcs"}, 32'(PC_s), 32'd1);
                    end else
                        check({nm, ".srcb"}, 32'(ALU_SrcB), (k == K_IZ) ? 32'd2 : (k == K_R) ? 32'd0 : 32'd1);
                end
                3'd4: en[1] = k == K_SW;
                3'd5: begin
                    en[2] = 1'b1;
                    check({nm, ".rd_s"}, 32'(rd_s), (k == K_R) ? 32'd1 : (k == K_JAL) ? 32'd2 : 32'd0);
                    check({nm, ".wd_s"}, 32'(w_data_s), (k == K_LW) ? 32'd1 : (k == K_JAL) ? 32'd2 : 32'd0);
                end
                default: ;
            endcase
            check({nm, ".en"}, 32'(enables()), 32'(en));
        end
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check({nm, ".cnt"}, 32'(inst_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [5:0] rop, rfn;
        int         sel;
        #1;
        check("rst.state", 32'(state), 32'd0);
        check("rst.en", 32'(enables()), 32'd0);
        check("rst.cnt", 32'(inst_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.hold", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle.state", 32'(state), 32'd0);
        check("idle.en", 32'(enables()), 32'd0);
        @(posedge clk);
        #1;
        run_instr("add", 6'b000000, 6'b100000, 1'b0);
        run_instr("lw", 6'b100011, 6'd0, 1'b0);
        run_instr("sw", 6'b101011, 6'd0, 1'b0);
        run_instr("beq_z1", 6'b000100, 6'd0, 1'b1);
        run_instr("beq_z0", 6'b000100, 6'd0, 1'b0);
        run_instr("bne_z0", 6'b000101, 6'd0, 1'b0);
        run_instr("ill", 6'b111111, 6'd0, 1'b0);
        run_instr("jal", 6'b000011, 6'd0, 1'b0);
        run_instr("j", 6'b000010, 6'd0, 1'b0);
        // reset asserted mid-cycle while sw sits in MEM
        op_code = 6'b101011;
        repeat (3) @(posedge clk);
        #1;
        check("abort.mem_state", 32'(state), 32'd4);
        check("abort.mem_wr", 32'(Mem_Write), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort.en", 32'(enables()), 32'd0);
        check("abort.state", 32'(state), 32'd0);
        check("abort.cnt", 32'(inst_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 13);
            rop = (sel < 13) ? OPS[sel] : 6'($urandom);
            rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : R_FN[$urandom_range(0, 7)];
            run_instr("rand", rop, rfn, 1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
